// File: rtl/tlp_fifo_arb.sv
// Packet-granular round-robin arbiter draining NUM_REQ first-word-fall-through TLP FIFOs
// onto a single 64-bit stream, tagging each packet with its source and aborting stalled packets.
module tlp_fifo_arb #(
    parameter int NUM_REQ   = 2,
    parameter int STALL_MAX = 500
) (
    input  logic                    pcie_clk,
    input  logic                    pcie_rst,
    input  logic [NUM_REQ-1:0]      req_empty,
    output logic [NUM_REQ-1:0]      req_rd_en,
    input  logic [NUM_REQ-1:0]      req_data_valid,
    input  logic [NUM_REQ-1:0]      req_tlast,
    input  logic [8*NUM_REQ-1:0]    req_tkeep,
    input  logic [64*NUM_REQ-1:0]   req_tdata,
    input  logic [12*NUM_REQ-1:0]   req_len,
    output logic                    m_tvalid,
    input  logic                    m_tready,
    output logic                    m_tlast,
    output logic [7:0]              m_tkeep,
    output logic [63:0]             m_tdata,
    output logic                    m_sof,
    output logic [11:0]             m_len,
    output logic [2:0]              m_src,
    output logic                    m_err,
    output logic [1:0]              fsm_state
);

    // Handshake: a beat transfers on a rising edge where m_tvalid && m_tready; while
    // m_tvalid && !m_tready every m_* output holds. A FIFO word leaves its FIFO on a rising
    // edge where req_rd_en[i] is high, and the next head must be presented the cycle after.

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        XFER  = 2'd1,
        ABORT = 2'd2
    } state_t;

    localparam logic [9:0] STALL_LIM = 10'(STALL_MAX);
    localparam logic [9:0] STALL_SAT = 10'h3FF;

    state_t      state;
    state_t      state_nxt;
    logic [2:0]  grant;
    logic [2:0]  last_grant;
    logic [9:0]  stall_cnt;
    logic        sent_any;

    logic        h_empty;
    logic        h_dv;
    logic        h_tlast;
    logic [7:0]  h_tkeep;
    logic [63:0] h_tdata;
    logic [11:0] h_len;

    logic        pick_valid;
    logic [2:0]  pick;

    logic        out_load;
    logic        bubble_pop;
    logic        data_pop;
    logic        stall_hit;

    logic        beat_valid;
    logic        beat_tlast;
    logic [7:0]  beat_tkeep;
    logic [63:0] beat_tdata;
    logic        beat_sof;
    logic        beat_err;

    assign fsm_state = state;

    // Head word of the currently granted FIFO.
    always_comb begin
        h_empty = 1'b1;
        h_dv    = 1'b0;
        h_tlast = 1'b0;
        h_tkeep = '0;
        h_tdata = '0;
        h_len   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant == 3'(i)) begin
                h_empty = req_empty[i];
                h_dv    = req_data_valid[i];
                h_tlast = req_tlast[i];
                h_tkeep = req_tkeep[i*8 +: 8];
                h_tdata = req_tdata[i*64 +: 64];
                h_len   = req_len[i*12 +: 12];
            end
        end
    end

    // Round-robin scan starting just after the previous winner, so it ranks last.
    always_comb begin
        pick_valid = 1'b0;
        pick       = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!pick_valid && (i == (int'(last_grant) + k) % NUM_REQ) && !req_empty[i]) begin
                    pick_valid = 1'b1;
                    pick       = 3'(i);
                end
            end
        end
    end

    assign out_load   = !m_tvalid || m_tready;
    assign bubble_pop = (state == XFER) && !h_empty && !h_dv;
    assign data_pop   = (state == XFER) && !h_empty && h_dv && out_load;
    assign stall_hit  = (stall_cnt == STALL_LIM);

    always_comb begin
        req_rd_en = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_rd_en[i] = (grant == 3'(i)) && (bubble_pop || data_pop) && !pcie_rst;
        end
    end

    always_comb begin
        state_nxt  = state;
        beat_valid = 1'b0;
        beat_tlast = 1'b0;
        beat_tkeep = '0;
        beat_tdata = '0;
        beat_sof   = 1'b0;
        beat_err   = 1'b0;
        case (state)
            IDLE: begin
                if (pick_valid) state_nxt = XFER;
            end
            XFER: begin
                if (data_pop) begin
                    beat_valid = 1'b1;
                    beat_tlast = h_tlast;
                    beat_tkeep = h_tkeep;
                    beat_tdata = h_tdata;
                    beat_sof   = !sent_any;
                    if (h_tlast) state_nxt = IDLE;
                end else if (stall_hit) begin
                    state_nxt = ABORT;
                end
            end
            ABORT: begin
                // A packet that never emitted a beat has nothing to terminate downstream.
                if (!sent_any) begin
                    state_nxt = IDLE;
                end else if (out_load) begin
                    beat_valid = 1'b1;
                    beat_tlast = 1'b1;
                    beat_err   = 1'b1;
                    state_nxt  = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge pcie_clk) begin
        if (pcie_rst) begin
            state      <= IDLE;
            grant      <= '0;
            last_grant <= 3'(NUM_REQ - 1);
            stall_cnt  <= '0;
            sent_any   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && pick_valid) begin
                grant      <= pick;
                last_grant <= pick;
                stall_cnt  <= '0;
                sent_any   <= 1'b0;
            end
            if (state == XFER) begin
                if (data_pop) begin
                    stall_cnt <= '0;
                    sent_any  <= 1'b1;
                end else if ((h_empty || !h_dv) && stall_cnt != STALL_SAT) begin
                    // Backpressure with data waiting is not a stall and leaves the count alone.
                    stall_cnt <= stall_cnt + 10'd1;
                end
            end
        end
    end

    always_ff @(posedge pcie_clk) begin
        if (pcie_rst) begin
            m_tvalid <= 1'b0;
            m_tlast  <= 1'b0;
            m_tkeep  <= '0;
            m_tdata  <= '0;
            m_sof    <= 1'b0;
            m_len    <= '0;
            m_src    <= '0;
            m_err    <= 1'b0;
        end else if (out_load) begin
            m_tvalid <= beat_valid;
            if (beat_valid) begin
                m_tlast <= beat_tlast;
                m_tkeep <= beat_tkeep;
                m_tdata <= beat_tdata;
                m_sof   <= beat_sof;
                m_src   <= grant;
                m_err   <= beat_err;
                if (beat_sof) m_len <= h_len;
            end
        end
    end

endmodule

// File: tb/tb_tlp_fifo_arb.sv
// Directed bench for tlp_fifo_arb: modelled requester FIFOs, expected-beat scoreboard,
// and immediate-assertion checks at each comparison point.
module tb_tlp_fifo_arb;

    logic          pcie_clk = 1'b0;
    logic          pcie_rst = 1'b1;
    logic [1:0]    req_empty = 2'b11;
    logic [1:0]    req_rd_en;
    logic [1:0]    req_data_valid = '0;
    logic [1:0]    req_tlast = '0;
    logic [15:0]   req_tkeep = '0;
    logic [127:0]  req_tdata = '0;
    logic [23:0]   req_len = '0;
    logic          m_tvalid;
    logic          m_tready = 1'b1;
    logic          m_tlast;
    logic [7:0]    m_tkeep;
    logic [63:0]   m_tdata;
    logic          m_sof;
    logic [11:0]   m_len;
    logic [2:0]    m_src;
    logic          m_err;
    logic [1:0]    fsm_state;

    tlp_fifo_arb #(.NUM_REQ(2), .STALL_MAX(8)) dut (
        .pcie_clk(pcie_clk), .pcie_rst(pcie_rst),
        .req_empty(req_empty), .req_rd_en(req_rd_en),
        .req_data_valid(req_data_valid), .req_tlast(req_tlast),
        .req_tkeep(req_tkeep), .req_tdata(req_tdata), .req_len(req_len),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
        .m_tkeep(m_tkeep), .m_tdata(m_tdata), .m_sof(m_sof), .m_len(m_len),
        .m_src(m_src), .m_err(m_err), .fsm_state(fsm_state)
    );

    // Clock / reset
    always #5 pcie_clk = ~pcie_clk;

    // FIFO word: {data_valid, tlast, tkeep[7:0], tdata[63:0], len[11:0]}
    logic [85:0] fq0[$];
    logic [85:0] fq1[$];
    // Beat: {tlast, tkeep[7:0], tdata[63:0], sof, len[11:0], src[2:0], err}
    logic [89:0] exp_q[$];

    int n_vec = 0;
    int n_err = 0;

    task automatic set_head(input int i, input logic empty, input logic [85:0] w);
        req_empty[i]           = empty;
        req_data_valid[i]      = empty ? 1'b0 : w[85];
        req_tlast[i]           = empty ? 1'b0 : w[84];
        req_tkeep[i*8 +: 8]    = empty ? 8'h00 : w[83:76];
        req_tdata[i*64 +: 64]  = empty ? 64'h0 : w[75:12];
        req_len[i*12 +: 12]    = empty ? 12'h0 : w[11:0];
    endtask

    task automatic refresh_heads();
        set_head(0, fq0.size() == 0, (fq0.size() == 0) ? 86'h0 : fq0[0]);
        set_head(1, fq1.size() == 0, (fq1.size() == 0) ? 86'h0 : fq1[0]);
    endtask

    // FIFO model: pops on the edge where req_rd_en was high, heads refreshed after the edge.
    always begin
        logic [1:0] pm;
        @(posedge pcie_clk);
        pm = req_rd_en;
        #1;
        if (pm[0] && fq0.size() > 0) void'(fq0.pop_front());
        if (pm[1] && fq1.size() > 0) void'(fq1.pop_front());
        refresh_heads();
        #2;
        refresh_heads();
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Driver tasks
    task automatic push_word(input int r, input logic [85:0] w);
        if (r == 0) fq0.push_back(w);
        else        fq1.push_back(w);
    endtask

    task automatic push_bubble(input int r);
        push_word(r, {1'b0, 1'b1, 8'hFF, {$urandom, $urandom}, 12'hFFF});
    endtask

    task automatic push_pkt(input int r, input int n, input logic [11:0] len,
                            input logic [7:0] last_keep, input int bub_pos);
        logic [63:0] d;
        logic [7:0]  k8;
        logic        last;
        for (int k = 0; k < n; k++) begin
            if (k == bub_pos) push_bubble(r);
            d    = {$urandom, $urandom};
            last = (k == n - 1);
            k8   = last ? last_keep : 8'hFF;
            push_word(r, {1'b1, last, k8, d, len});
            exp_q.push_back({last, k8, d, (k == 0), len, 3'(r), 1'b0});
        end
    endtask

    task automatic do_reset();
        pcie_rst = 1'b1;
        m_tready = 1'b1;
        fq0.delete();
        fq1.delete();
        exp_q.delete();
        @(posedge pcie_clk);
        #1;
        check("rst_outputs", {req_rd_en, m_tvalid, m_tlast, m_tkeep, m_tdata, m_sof, m_len, m_src, m_err}, '0);
        check("rst_state", fsm_state, 2'd0);
        #1 pcie_rst = 1'b0;
        @(posedge pcie_clk);
        #2;
    endtask

    task automatic wait_valid(input int max_cyc, output int cyc);
        cyc = 0;
        while (cyc < max_cyc) begin
            @(posedge pcie_clk);
            #1;
            cyc++;
            if (m_tvalid) break;
        end
    endtask

    task automatic drain(input string tag);
        for (int c = 0; c < 300 && exp_q.size() != 0; c++) @(posedge pcie_clk);
        repeat (3) @(posedge pcie_clk);
        #1;
        check(tag, exp_q.size(), 0);
    endtask

    initial begin
        int cyc;
        int gap;
        logic [90:0] cur;
        logic [90:0] prev;
        logic        hold_prev;

        // Scoreboard monitor: compares accepted beats and checks the output holds under backpressure.
        fork
            begin
                hold_prev = 1'b0;
                prev      = '0;
                forever begin
                    @(negedge pcie_clk);
                    cur = {m_tvalid, m_tlast, m_tkeep, m_tdata, m_sof, m_len, m_src, m_err};
                    if (pcie_rst) begin
                        hold_prev = 1'b0;
                    end else begin
                        if (hold_prev) check("hold_stable", cur, prev);
                        if (m_tvalid && !m_tready) check("bp_pop", req_rd_en & req_data_valid, 2'b00);
                        if (m_tvalid && m_tready) begin
                            if (exp_q.size() == 0) check("unexpected_beat", m_tvalid, 1'b0);
                            else check("beat", cur[89:0], exp_q.pop_front());
                        end
                        hold_prev = m_tvalid && !m_tready;
                        prev      = cur;
                    end
                end
            end
            begin
                #400000;
                $display("FAIL watchdog: simulation time limit reached");
                $fatal(1, "watchdog");
            end
        join_none

        // 1. Single packet and first-beat latency
        do_reset();
        push_pkt(0, 3, 12'd20, 8'h0F, -1);
        wait_valid(20, cyc);
        check("first_beat_latency", cyc, 2);
        check("first_beat_sof", {m_tvalid, m_sof, m_src}, {1'b1, 1'b1, 3'd0});
        @(posedge pcie_clk); #1;
        check("beat2_back_to_back", m_tvalid, 1'b1);
        @(posedge pcie_clk); #1;
        check("beat3_last", {m_tvalid, m_tlast, m_len}, {1'b1, 1'b1, 12'd20});
        drain("drain_single");

        // 2. Fairness between two always-ready requesters
        do_reset();
        for (int p = 0; p < 4; p++) begin
            push_pkt(0, 1, 12'(8 + p), 8'h03, -1);
            push_pkt(1, 1, 12'(16 + p), 8'h7F, -1);
        end
        drain("drain_fair");

        // 3. Backpressure mid-packet with a bubble queued behind the current beat
        do_reset();
        push_pkt(0, 5, 12'd36, 8'h0F, 1);
        wait_valid(20, cyc);
        check("bp_first_valid", m_tvalid, 1'b1);
        @(posedge pcie_clk); #1;
        m_tready = 1'b0;
        repeat (5) @(posedge pcie_clk);
        #1;
        check("bp_no_data_pop", req_rd_en, 2'b00);
        check("bp_fifo_depth", fq0.size(), 3);
        m_tready = 1'b1;
        drain("drain_bp");

        // 4. Bubbles between and inside packets, plus a bubble-only grant at the end
        do_reset();
        push_bubble(1);
        push_pkt(1, 3, 12'd24, 8'h0F, 1);
        push_bubble(1);
        push_pkt(1, 1, 12'd8, 8'h01, -1);
        push_bubble(1);
        drain("drain_bubble");
        repeat (20) @(posedge pcie_clk);
        #1;
        check("bubble_only_idle", {fsm_state, m_tvalid, 2'(fq1.size())}, {2'd0, 1'b0, 2'd0});

        // 5. Stall abort after one non-last word from req1
        do_reset();
        begin
            logic [63:0] d;
            d = {$urandom, $urandom};
            push_word(1, {1'b1, 1'b0, 8'hFF, d, 12'd40});
            exp_q.push_back({1'b0, 8'hFF, d, 1'b1, 12'd40, 3'd1, 1'b0});
            exp_q.push_back({1'b1, 8'h00, 64'h0, 1'b0, 12'd40, 3'd1, 1'b1});
        end
        wait_valid(20, cyc);
        check("stall_first_beat", {m_tvalid, m_src}, {1'b1, 3'd1});
        gap = 0;
        while (gap < 40) begin
            @(posedge pcie_clk); #1;
            gap++;
            if (m_tvalid && m_err) break;
        end
        check("abort_seen", {m_tvalid, m_err, m_tlast}, 3'b111);
        check("abort_gap_in_range", (gap >= 8 && gap <= 12), 1'b1);
        repeat (2) @(posedge pcie_clk);
        #1;
        check("abort_back_idle", fsm_state, 2'd0);
        push_pkt(0, 2, 12'd12, 8'hFF, -1);
        drain("drain_after_abort");

        // 6. Reset during beat 2 of 4
        do_reset();
        push_pkt(0, 4, 12'd32, 8'hFF, -1);
        wait_valid(20, cyc);
        @(posedge pcie_clk); #1;
        check("mid_beat2", {m_tvalid, m_sof}, 2'b10);
        pcie_rst = 1'b1;
        exp_q.delete();
        @(posedge pcie_clk); #1;
        check("mid_rst_outputs", {req_rd_en, m_tvalid, m_tlast, m_tkeep, m_tdata, m_sof, m_len, m_src, m_err}, '0);
        pcie_rst = 1'b0;
        fq0.delete();
        fq1.delete();
        push_pkt(0, 1, 12'd4, 8'h0F, -1);
        push_pkt(1, 1, 12'd6, 8'h3F, -1);
        wait_valid(20, cyc);
        check("post_rst_winner", {m_tvalid, m_src}, {1'b1, 3'd0});
        drain("drain_post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
